// File: rtl/drw_pkg.sv
// Shared types and constants for the draw-engine pixel path.
package drw_pkg;

    localparam int unsigned BURST_LEN = 32;
    localparam int unsigned CNT_W     = 11;
    localparam int unsigned PIX_W     = 32;

    localparam logic CMD_PATBLT = 1'b0;
    localparam logic CMD_BITBLT = 1'b1;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } argb_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FLUSH} state_t;

    // Map alpha 0..255 onto 0..256 so that 255 selects the source exactly.
    function automatic logic [8:0] alpha_expand(input logic [7:0] a);
        return 9'(a) + 9'(a[7]);
    endfunction

endpackage

// File: rtl/drw_blend_ch.sv
// One 8-bit colour channel of the source-over-destination alpha blend.
module drw_blend_ch (
    input  logic [7:0] s,
    input  logic [7:0] d,
    input  logic [8:0] ae,
    output logic [7:0] blended
);

    logic [16:0] sum;

    // Weights sum to 256, so the result always fits in 16 bits.
    assign sum     = 17'(s) * 17'(ae) + 17'(d) * (17'd256 - 17'(ae));
    assign blended = 8'(sum >> 8);

endmodule

// File: rtl/drw_pixproc.sv
// Pixel stage: pops SRC/DST (or uses pattern), optionally blends, pushes LINE_LEN
// pixels to WRT, then discards the read-burst surplus from the source FIFOs.
module drw_pixproc #(
    parameter int unsigned BURST_LEN = drw_pkg::BURST_LEN
) (
    input  logic        CLK,
    input  logic        ARST,
    input  logic        LINE_START,
    input  logic [10:0] LINE_LEN,
    input  logic        CMD_MODE,
    input  logic        PARAM_BLEND,
    input  logic [31:0] PAT_COLOR,
    output logic        PROC_BUSY,
    input  logic        SRC_FIFO_EMPTY,
    output logic        SRC_FIFO_RD,
    input  logic [31:0] SRC_FIFO_RDATA,
    input  logic        DST_FIFO_EMPTY,
    output logic        DST_FIFO_RD,
    input  logic [31:0] DST_FIFO_RDATA,
    input  logic        WRT_FIFO_FULL,
    output logic        WRT_FIFO_WR,
    output logic [31:0] WRT_FIFO_WDATA
);
    import drw_pkg::*;

    localparam int unsigned PAD_W = $clog2(BURST_LEN);

    state_t           state;
    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] issue_cnt;
    logic [CNT_W-1:0] out_cnt;
    logic             mode;
    logic             blend;
    argb_t            pat;
    logic [PAD_W-1:0] src_pad;
    logic [PAD_W-1:0] dst_pad;
    logic [PAD_W-1:0] pad;
    logic             s1_valid;
    logic             s2_valid;
    argb_t            s1_src;
    argb_t            s1_dst;
    argb_t            s2_pix;
    argb_t            blend_pix;
    logic [8:0]       ae;
    logic [7:0]       blend_r;
    logic [7:0]       blend_g;
    logic [7:0]       blend_b;
    logic             need_src;
    logic             need_dst;
    logic             en;
    logic             issue;
    logic             src_drain;
    logic             dst_drain;
    logic             unused_dst_alpha;

    assign need_src = (mode == CMD_BITBLT);
    assign need_dst = blend;
    assign en       = !(s2_valid && WRT_FIFO_FULL);
    assign issue    = (state == RUN) && (issue_cnt < len) && en
                    && (!need_src || !SRC_FIFO_EMPTY)
                    && (!need_dst || !DST_FIFO_EMPTY);

    // Surplus pops are independent of the output stall and of each other.
    assign src_drain = (state == DRAIN) && (src_pad != '0) && !SRC_FIFO_EMPTY;
    assign dst_drain = (state == DRAIN) && (dst_pad != '0) && !DST_FIFO_EMPTY;
    assign pad       = PAD_W'(CNT_W'(0) - len);

    assign SRC_FIFO_RD    = (issue && need_src) || src_drain;
    assign DST_FIFO_RD    = (issue && need_dst) || dst_drain;
    assign WRT_FIFO_WR    = s2_valid && !WRT_FIFO_FULL;
    assign WRT_FIFO_WDATA = s2_pix;

    assign ae               = alpha_expand(s1_src.a);
    assign blend_pix        = {8'hFF, blend_r, blend_g, blend_b};
    assign unused_dst_alpha = ^s1_dst.a;

    drw_blend_ch u_blend_r (.s(s1_src.r), .d(s1_dst.r), .ae(ae), .blended(blend_r));
    drw_blend_ch u_blend_g (.s(s1_src.g), .d(s1_dst.g), .ae(ae), .blended(blend_g));
    drw_blend_ch u_blend_b (.s(s1_src.b), .d(s1_dst.b), .ae(ae), .blended(blend_b));

    always_ff @(posedge CLK) begin
        if (ARST) begin
            state     <= IDLE;
            PROC_BUSY <= 1'b0;
            len       <= '0;
            mode      <= 1'b0;
            blend     <= 1'b0;
            pat       <= '0;
            issue_cnt <= '0;
            out_cnt   <= '0;
            src_pad   <= '0;
            dst_pad   <= '0;
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s1_src    <= '0;
            s1_dst    <= '0;
            s2_pix    <= '0;
        end else begin
            if (en) begin
                s1_valid <= issue;
                s1_src   <= need_src ? argb_t'(SRC_FIFO_RDATA) : pat;
                s1_dst   <= argb_t'(DST_FIFO_RDATA);
                s2_valid <= s1_valid;
                s2_pix   <= blend ? blend_pix : s1_src;
            end
            if (issue)       issue_cnt <= issue_cnt + CNT_W'(1);
            if (WRT_FIFO_WR) out_cnt   <= out_cnt + CNT_W'(1);
            if (src_drain)   src_pad   <= src_pad - PAD_W'(1);
            if (dst_drain)   dst_pad   <= dst_pad - PAD_W'(1);

            case (state)
                IDLE: begin
                    if (LINE_START) begin
                        len       <= LINE_LEN;
                        mode      <= CMD_MODE;
                        blend     <= PARAM_BLEND;
                        pat       <= argb_t'(PAT_COLOR);
                        issue_cnt <= '0;
                        out_cnt   <= '0;
                        if (LINE_LEN != '0) begin
                            state     <= RUN;
                            PROC_BUSY <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue_cnt == len) begin
                        src_pad <= need_src ? pad : '0;
                        dst_pad <= need_dst ? pad : '0;
                        state   <= (pad == '0 || (!need_src && !need_dst)) ? FLUSH : DRAIN;
                    end
                end
                DRAIN: begin
                    if (src_pad == '0 && dst_pad == '0) state <= FLUSH;
                end
                FLUSH: begin
                    if (out_cnt == len) begin
                        state     <= IDLE;
                        PROC_BUSY <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_drw_pixproc.sv
// Directed bench for drw_pixproc with FIFO models and an output scoreboard.
module tb_drw_pixproc;

    logic        CLK;
    logic        ARST;
    logic        LINE_START;
    logic [10:0] LINE_LEN;
    logic        CMD_MODE;
    logic        PARAM_BLEND;
    logic [31:0] PAT_COLOR;
    logic        PROC_BUSY;
    logic        SRC_FIFO_EMPTY;
    logic        SRC_FIFO_RD;
    logic [31:0] SRC_FIFO_RDATA;
    logic        DST_FIFO_EMPTY;
    logic        DST_FIFO_RD;
    logic [31:0] DST_FIFO_RDATA;
    logic        WRT_FIFO_FULL;
    logic        WRT_FIFO_WR;
    logic [31:0] WRT_FIFO_WDATA;

    drw_pixproc dut (
        .CLK(CLK), .ARST(ARST), .LINE_START(LINE_START), .LINE_LEN(LINE_LEN),
        .CMD_MODE(CMD_MODE), .PARAM_BLEND(PARAM_BLEND), .PAT_COLOR(PAT_COLOR),
        .PROC_BUSY(PROC_BUSY),
        .SRC_FIFO_EMPTY(SRC_FIFO_EMPTY), .SRC_FIFO_RD(SRC_FIFO_RD), .SRC_FIFO_RDATA(SRC_FIFO_RDATA),
        .DST_FIFO_EMPTY(DST_FIFO_EMPTY), .DST_FIFO_RD(DST_FIFO_RD), .DST_FIFO_RDATA(DST_FIFO_RDATA),
        .WRT_FIFO_FULL(WRT_FIFO_FULL), .WRT_FIFO_WR(WRT_FIFO_WR), .WRT_FIFO_WDATA(WRT_FIFO_WDATA)
    );

    logic [31:0] src_q[$];
    logic [31:0] dst_q[$];
    logic [31:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pushes, src_pops, dst_pops, first_pop_cyc, first_push_cyc;
    bit gaps_on = 0;
    bit full_force = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] blend_ref(input logic [31:0] s, input logic [31:0] d);
        int ae;
        logic [31:0] r;
        ae = int'(s[31:24]) + (s[31] ? 1 : 0);
        r = 32'hFF00_0000;
        for (int c = 0; c < 3; c++) begin
            int sc, dc;
            sc = int'((s >> (8 * c)) & 32'hFF);
            dc = int'((d >> (8 * c)) & 32'hFF);
            r = r | (32'(((sc * ae + dc * (256 - ae)) >> 8) & 255) << (8 * c));
        end
        return r;
    endfunction

    // FIFO models and output monitor: drive at negedge, sample 1 ns later.
    always @(negedge CLK) begin
        cyc++;
        SRC_FIFO_EMPTY = (src_q.size() == 0) || (gaps_on && $urandom_range(0, 3) == 0);
        DST_FIFO_EMPTY = (dst_q.size() == 0) || (gaps_on && $urandom_range(0, 3) == 0);
        SRC_FIFO_RDATA = (src_q.size() != 0) ? src_q[0] : 32'h0;
        DST_FIFO_RDATA = (dst_q.size() != 0) ? dst_q[0] : 32'h0;
        WRT_FIFO_FULL  = full_force;
        #1;
        if (SRC_FIFO_RD) begin
            src_pops++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            if (src_q.size() != 0) void'(src_q.pop_front());
        end
        if (DST_FIFO_RD) begin
            dst_pops++;
            if (dst_q.size() != 0) void'(dst_q.pop_front());
        end
        if (WRT_FIFO_WR) begin
            pushes++;
            if (first_push_cyc < 0) first_push_cyc = cyc;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL push_unexpected: observed=%h expected=none", WRT_FIFO_WDATA);
            end
            if (exp_q.size() != 0) check("push_data", WRT_FIFO_WDATA, exp_q.pop_front());
        end
    end

    task automatic clear_counts();
        pushes = 0; src_pops = 0; dst_pops = 0;
        first_pop_cyc = -1; first_push_cyc = -1;
    endtask

    task automatic start_line(input logic [10:0] len, input logic mode, input logic blend,
                              input logic [31:0] pat);
        @(negedge CLK);
        LINE_START = 1'b1; LINE_LEN = len; CMD_MODE = mode; PARAM_BLEND = blend; PAT_COLOR = pat;
        @(negedge CLK);
        LINE_START = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        #2;
        while (PROC_BUSY && n < budget) begin
            @(negedge CLK);
            #2;
            n++;
        end
        check({tag, "_idle"}, 32'(PROC_BUSY), 32'h0);
        check({tag, "_exp_left"}, 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        ARST = 1'b1; LINE_START = 1'b0; LINE_LEN = '0; CMD_MODE = 1'b0;
        PARAM_BLEND = 1'b0; PAT_COLOR = '0;
        clear_counts();
        repeat (3) @(negedge CLK);
        #2;
        check("rst_busy", 32'(PROC_BUSY), 32'h0);
        check("rst_wr", 32'(WRT_FIFO_WR), 32'h0);
        check("rst_wdata", WRT_FIFO_WDATA, 32'h0);
        ARST = 1'b0;

        // PATBLT, no blend: pattern only, no FIFO traffic
        clear_counts();
        repeat (5) exp_q.push_back(32'h1122_3344);
        start_line(11'd5, 1'b0, 1'b0, 32'h1122_3344);
        #2;
        check("t1_busy_on", 32'(PROC_BUSY), 32'h1);
        wait_idle(100, "t1");
        check("t1_pushes", 32'(pushes), 32'd5);
        check("t1_src_pops", 32'(src_pops), 32'd0);
        check("t1_dst_pops", 32'(dst_pops), 32'd0);

        // BITBLT ramp with surplus discard to the 64-pixel boundary
        clear_counts();
        for (int i = 0; i < 64; i++) src_q.push_back(32'(i));
        for (int i = 0; i < 40; i++) exp_q.push_back(32'(i));
        start_line(11'd40, 1'b1, 1'b0, 32'h0);
        wait_idle(300, "t2");
        check("t2_pushes", 32'(pushes), 32'd40);
        check("t2_src_pops", 32'(src_pops), 32'd64);
        check("t2_src_left", 32'(src_q.size()), 32'd0);
        check("t2_latency", 32'(first_push_cyc - first_pop_cyc), 32'd2);

        // Blend, full burst: no surplus
        clear_counts();
        repeat (32) begin
            src_q.push_back(32'h80FF_0000);
            dst_q.push_back(32'hFF00_00FF);
            exp_q.push_back(32'hFF80_007E);
        end
        start_line(11'd32, 1'b1, 1'b1, 32'h0);
        wait_idle(300, "t3");
        check("t3_src_pops", 32'(src_pops), 32'd32);
        check("t3_dst_pops", 32'(dst_pops), 32'd32);

        // Blend alpha extremes, 30 surplus entries per FIFO
        clear_counts();
        src_q.push_back(32'hFFFF_0000); src_q.push_back(32'h00FF_0000);
        dst_q.push_back(32'hFF00_00FF); dst_q.push_back(32'hFF00_00FF);
        repeat (30) begin src_q.push_back(32'h5555_5555); dst_q.push_back(32'hAAAA_AAAA); end
        exp_q.push_back(32'hFFFF_0000); exp_q.push_back(32'hFF00_00FF);
        start_line(11'd2, 1'b1, 1'b1, 32'h0);
        wait_idle(300, "t3b");
        check("t3b_src_left", 32'(src_q.size()), 32'd0);
        check("t3b_dst_left", 32'(dst_q.size()), 32'd0);

        // Random blend data with EMPTY gaps and a 10-cycle output stall
        clear_counts();
        for (int i = 0; i < 32; i++) begin
            logic [31:0] s, d;
            s = $urandom();
            d = $urandom();
            src_q.push_back(s);
            dst_q.push_back(d);
            if (i < 20) exp_q.push_back(blend_ref(s, d));
        end
        gaps_on = 1;
        start_line(11'd20, 1'b1, 1'b1, 32'h0);
        repeat (6) @(negedge CLK);
        full_force = 1;
        repeat (10) @(negedge CLK);
        full_force = 0;
        wait_idle(500, "t4");
        gaps_on = 0;
        check("t4_pushes", 32'(pushes), 32'd20);
        check("t4_src_left", 32'(src_q.size()), 32'd0);
        check("t4_dst_left", 32'(dst_q.size()), 32'd0);

        // Reset in the middle of a line, then a normal short line
        clear_counts();
        for (int i = 0; i < 32; i++) begin
            src_q.push_back(32'h100 + 32'(i));
            if (i < 30) exp_q.push_back(32'h100 + 32'(i));
        end
        start_line(11'd30, 1'b1, 1'b0, 32'h0);
        begin
            int n = 0;
            while (src_pops < 7 && n < 100) begin @(negedge CLK); #2; n++; end
            check("t5_reach_px7", 32'(n < 100), 32'h1);
        end
        ARST = 1'b1;
        @(negedge CLK);
        ARST = 1'b0;
        #2;
        check("t5_busy", 32'(PROC_BUSY), 32'h0);
        check("t5_src_rd", 32'(SRC_FIFO_RD), 32'h0);
        check("t5_dst_rd", 32'(DST_FIFO_RD), 32'h0);
        check("t5_wr", 32'(WRT_FIFO_WR), 32'h0);
        check("t5_wdata", WRT_FIFO_WDATA, 32'h0);
        exp_q.delete();
        src_q.delete();
        clear_counts();
        for (int i = 0; i < 32; i++) src_q.push_back(32'hC0DE_0000 + 32'(i));
        for (int i = 0; i < 3; i++) exp_q.push_back(32'hC0DE_0000 + 32'(i));
        start_line(11'd3, 1'b1, 1'b0, 32'h0);
        wait_idle(200, "t5b");
        check("t5b_pushes", 32'(pushes), 32'd3);
        check("t5b_src_pops", 32'(src_pops), 32'd32);

        // Zero-length line does nothing
        clear_counts();
        start_line(11'd0, 1'b0, 1'b0, 32'h1234_5678);
        #2;
        check("t6_busy_len0", 32'(PROC_BUSY), 32'h0);
        repeat (5) @(negedge CLK);
        check("t6_pushes_len0", 32'(pushes), 32'd0);

        // A second start while busy is ignored
        clear_counts();
        repeat (4) exp_q.push_back(32'h0BAD_F00D);
        start_line(11'd4, 1'b0, 1'b0, 32'h0BAD_F00D);
        start_line(11'd9, 1'b0, 1'b0, 32'hDEAD_BEEF);
        wait_idle(100, "t6");
        repeat (5) @(negedge CLK);
        check("t6_pushes", 32'(pushes), 32'd4);
        check("t6_busy_after", 32'(PROC_BUSY), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
